// File: rtl/ping_scheduler.sv
// Ping sequencer: transmit burst, blanking, echo listen window, holdoff.
// Measures echo time of flight in clocks from the first transmit cycle.
module ping_scheduler #(
    parameter int TX_CYCLES      = 1000,
    parameter int BLANK_CYCLES   = 500,
    parameter int LISTEN_CYCLES  = 1_000_000,
    parameter int HOLDOFF_CYCLES = 100_000,
    localparam int TW = $clog2(TX_CYCLES + BLANK_CYCLES + LISTEN_CYCLES)
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    input  logic          enable_in,
    input  logic          trigger_in,
    input  logic          echo_in,
    output logic          tx_out,
    output logic          busy_out,
    output logic [TW-1:0] tof_out,
    output logic          tof_valid_out,
    output logic          timeout_out,
    output logic [15:0]   ping_count_out
);

    localparam int M1 = (TX_CYCLES > BLANK_CYCLES) ? TX_CYCLES : BLANK_CYCLES;
    localparam int M2 = (LISTEN_CYCLES > HOLDOFF_CYCLES) ? LISTEN_CYCLES : HOLDOFF_CYCLES;
    localparam int MAXC = (M1 > M2) ? M1 : M2;
    localparam int CW = $clog2(MAXC + 1);

    localparam logic [CW-1:0] TX_LAST     = CW'(TX_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST  = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] LISTEN_LAST = CW'(LISTEN_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLDOFF_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX,
        S_BLANK,
        S_LISTEN,
        S_HOLD
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_timer;
    logic [TW-1:0] r_tof_cnt;
    logic [TW-1:0] r_tof;
    logic          r_tx;
    logic          r_busy;
    logic          r_tof_valid;
    logic          r_timeout;
    logic [15:0]   r_ping_cnt;
    logic          w_start;

    assign w_start = enable_in | trigger_in;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_tof_cnt   <= '0;
            r_tof       <= '0;
            r_tx        <= 1'b0;
            r_busy      <= 1'b0;
            r_tof_valid <= 1'b0;
            r_timeout   <= 1'b0;
            r_ping_cnt  <= '0;
        end else begin
            r_tof_valid <= 1'b0;
            r_timeout   <= 1'b0;
            r_timer     <= r_timer + CW'(1);
            r_tof_cnt   <= r_tof_cnt + TW'(1);
            unique case (r_state)
                S_IDLE: begin
                    r_timer   <= '0;
                    r_tof_cnt <= '0;
                    if (w_start) begin
                        r_state    <= S_TX;
                        r_tx       <= 1'b1;
                        r_busy     <= 1'b1;
                        r_ping_cnt <= r_ping_cnt + 16'd1;
                    end
                end
                S_TX: begin
                    if (r_timer == TX_LAST) begin
                        r_state <= S_BLANK;
                        r_tx    <= 1'b0;
                        r_timer <= '0;
                    end
                end
                S_BLANK: begin
                    if (r_timer == BLANK_LAST) begin
                        r_state <= S_LISTEN;
                        r_timer <= '0;
                    end
                end
                S_LISTEN: begin
                    // an echo on the final listen cycle takes priority over the timeout
                    if (echo_in) begin
                        r_tof       <= r_tof_cnt;
                        r_tof_valid <= 1'b1;
                        r_state     <= S_HOLD;
                        r_timer     <= '0;
                    end else if (r_timer == LISTEN_LAST) begin
                        r_timeout <= 1'b1;
                        r_state   <= S_HOLD;
                        r_timer   <= '0;
                    end
                end
                S_HOLD: begin
                    r_tof_cnt <= r_tof_cnt;
                    if (r_timer == HOLD_LAST) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_timer <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_tx    <= 1'b0;
                end
            endcase
        end
    end

    assign tx_out         = r_tx;
    assign busy_out       = r_busy;
    assign tof_out        = r_tof;
    assign tof_valid_out  = r_tof_valid;
    assign timeout_out    = r_timeout;
    assign ping_count_out = r_ping_cnt;

endmodule

// File: tb/tb_ping_scheduler.sv
// Bench for ping_scheduler with TX=4, BLANK=2, LISTEN=10, HOLDOFF=3.
// Expected strobes are queued at stimulus time and checked when the DUT emits them.
module tb_ping_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable_in;
    logic        trigger_in;
    logic        echo_in;
    logic        tx_out;
    logic        busy_out;
    logic [3:0]  tof_out;
    logic        tof_valid_out;
    logic        timeout_out;
    logic [15:0] ping_count_out;

    typedef struct {
        logic       to;
        logic [3:0] tof;
    } sb_t;

    sb_t         sbq[$];
    int          rises[$];
    int          cyc = 0;
    logic        tx_q = 1'b0;
    logic [3:0]  m_tof = '0;
    logic [15:0] m_cnt = '0;
    int          n_chk = 0;
    int          n_fail = 0;

    ping_scheduler #(
        .TX_CYCLES(4),
        .BLANK_CYCLES(2),
        .LISTEN_CYCLES(10),
        .HOLDOFF_CYCLES(3)
    ) dut (
        .clk_in(clk),
        .rst_n_in(rst_n),
        .enable_in(enable_in),
        .trigger_in(trigger_in),
        .echo_in(echo_in),
        .tx_out(tx_out),
        .busy_out(busy_out),
        .tof_out(tof_out),
        .tof_valid_out(tof_valid_out),
        .timeout_out(timeout_out),
        .ping_count_out(ping_count_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        sb_t e;
        if (tx_out && !tx_q) rises.push_back(cyc);
        tx_q <= tx_out;
        if (rst_n && (tof_valid_out || timeout_out)) begin
            chk("one_strobe", {31'd0, tof_valid_out & timeout_out}, 0);
            if (sbq.size() == 0) begin
                chk("spurious_strobe", sbq.size(), 1);
            end else begin
                e = sbq.pop_front();
                chk("strobe_kind", {31'd0, timeout_out}, {31'd0, e.to});
                chk("tof_out", {28'd0, tof_out}, {28'd0, e.tof});
            end
        end
    end

    // Caller is positioned at a negedge with the DUT idle.
    task automatic run_ping(input int echo_at, input bit noisy);
        sb_t e;
        int  last;
        e.to  = !(echo_at >= 6 && echo_at <= 15);
        e.tof = e.to ? m_tof : echo_at[3:0];
        m_tof = e.tof;
        sbq.push_back(e);
        m_cnt = m_cnt + 16'd1;
        last  = e.to ? 19 : echo_at + 4;
        trigger_in = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            trigger_in = (k == 2);
            echo_in    = (k == echo_at) || (noisy && k < 6);
            if (k < 6) chk("tx_out", {31'd0, tx_out}, {31'd0, k < 4});
            if (k == last - 1) chk("busy_hold", {31'd0, busy_out}, 1);
            if (k == last) chk("busy_idle", {31'd0, busy_out}, 0);
        end
        echo_in    = 1'b0;
        trigger_in = 1'b0;
        chk("ping_cnt", {16'd0, ping_count_out}, {16'd0, m_cnt});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sb_t e;
        rst_n      = 1'b0;
        enable_in  = 1'b0;
        trigger_in = 1'b0;
        echo_in    = 1'b0;
        #12;
        chk("rst_tx", {31'd0, tx_out}, 0);
        chk("rst_busy", {31'd0, busy_out}, 0);
        chk("rst_tof", {28'd0, tof_out}, 0);
        chk("rst_strobes", {30'd0, tof_valid_out, timeout_out}, 0);
        chk("rst_cnt", {16'd0, ping_count_out}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_ping(8, 1'b0);
        run_ping(-1, 1'b1);
        run_ping(15, 1'b0);
        run_ping(6, 1'b1);

        // continuous ranging, stray triggers mid-ping, enable dropped in ping 3
        rises.delete();
        enable_in = 1'b1;
        for (int p = 0; p < 3; p++) begin
            e.to  = 1'b1;
            e.tof = m_tof;
            sbq.push_back(e);
        end
        m_cnt = m_cnt + 16'd3;
        for (int j = 1; j <= 41; j++) begin
            @(negedge clk);
            trigger_in = (j == 8) || (j == 30);
        end
        enable_in  = 1'b0;
        trigger_in = 1'b0;
        repeat (19) @(negedge clk);
        chk("en_idle", {31'd0, busy_out}, 0);
        chk("en_cnt", {16'd0, ping_count_out}, {16'd0, m_cnt});
        chk("en_rises", rises.size(), 3);
        if (rises.size() >= 3) begin
            chk("en_period1", rises[1] - rises[0], 20);
            chk("en_period2", rises[2] - rises[1], 20);
        end
        repeat (3) @(negedge clk);
        chk("en_stays_idle", {31'd0, busy_out}, 0);

        // counter wrap
        force dut.r_ping_cnt = 16'hFFFF;
        #1;
        release dut.r_ping_cnt;
        @(negedge clk);
        m_cnt = 16'hFFFF;
        run_ping(10, 1'b0);
        run_ping(-1, 1'b0);

        // asynchronous reset mid-listen
        trigger_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        trigger_in = 1'b0;
        repeat (8) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_tx", {31'd0, tx_out}, 0);
        chk("arst_busy", {31'd0, busy_out}, 0);
        chk("arst_tof", {28'd0, tof_out}, 0);
        chk("arst_strobes", {30'd0, tof_valid_out, timeout_out}, 0);
        chk("arst_cnt", {16'd0, ping_count_out}, 0);
        m_cnt = '0;
        m_tof = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_ping(12, 1'b0);

        repeat (4) @(negedge clk);
        chk("sb_empty", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
